ofdm_subcarrier_mapper: RTL and testbench

- Downstream neighbour of the transmitter frame stage. It consumes the completed FRAME_BITS-wide coded/interleaved frame, which is presented as a level "ready" plus a parallel bus.
- Maps the frame onto 802.11a OFDM symbols: BPSK or QPSK data, four BPSK pilots with PRBS polarity, and DC/guard nulls.
- Streams one 64-bin IFFT-ordered subcarrier per accepted beat to the IFFT stage, using a valid/ready handshake.

---
 rtl/ofdm_subcarrier_mapper_pkg.sv | 66 ++++++
 rtl/ofdm_subcarrier_mapper_pilot_prbs.sv | 31 +++
 rtl/ofdm_subcarrier_mapper.sv | 162 ++++++++++++++++
 tb/tb_ofdm_subcarrier_mapper.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_subcarrier_mapper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_subcarrier_mapper_pkg
// Brief    : Shared types, constants and bin-map helper for the 802.11a
//            OFDM subcarrier mapper.
// Revision : 1.0 - initial release
// ============================================================================
package ofdm_subcarrier_mapper_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int NUM_BINS   = 64;
  localparam int NUM_PILOTS = 4;

  // Pilot bins for s = -21, -7, +7, +21 and their base polarity (1 = negative)
  localparam logic [5:0] PILOT_BIN [NUM_PILOTS] = '{6'd43, 6'd57, 6'd7, 6'd21};
  localparam logic       PILOT_NEG [NUM_PILOTS] = '{1'b0, 1'b0, 1'b0, 1'b1};

  localparam logic [6:0] PRBS_SEED = 7'h7F;

  typedef struct packed {
    logic       is_data;
    logic       is_pilot;
    logic [5:0] d;
  } bin_info_t;

  // Classify an IFFT bin and, for data bins, return the data index 0..47
  function automatic bin_info_t bin_to_data_idx(input logic [5:0] b);
    bin_info_t r;
    r = '0;
    if (b >= 6'd1 && b <= 6'd26) begin
      r.is_data = 1'b1;
      if (b <= 6'd6)       r.d = b + 6'd23;
      else if (b <= 6'd20) r.d = b + 6'd22;
      else                 r.d = b + 6'd21;
    end else if (b >= 6'd38) begin
      r.is_data = 1'b1;
      if (b <= 6'd42)      r.d = b - 6'd38;
      else if (b <= 6'd56) r.d = b - 6'd39;
      else                 r.d = b - 6'd40;
    end
    for (int k = 0; k < NUM_PILOTS; k++) begin
      if (b == PILOT_BIN[k]) begin
        r.is_data  = 1'b0;
        r.is_pilot = 1'b1;
        r.d        = '0;
      end
    end
    return r;
  endfunction

  // Base polarity of a pilot bin (1 = -1); 0 for non-pilot bins
  function automatic logic pilot_base_neg(input logic [5:0] b);
    logic neg;
    neg = 1'b0;
    for (int k = 0; k < NUM_PILOTS; k++) begin
      if (b == PILOT_BIN[k]) neg = PILOT_NEG[k];
    end
    return neg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ofdm_subcarrier_mapper_pilot_prbs.sv
`default_nettype none
// ============================================================================
// Module   : pilot_prbs
// Brief    : 7-bit x^7 + x^4 + 1 LFSR giving the per-symbol pilot polarity.
// Revision : 1.0 - initial release
// ============================================================================
module pilot_prbs
  import ofdm_subcarrier_mapper_pkg::*;
(
  input  logic Clk,
  input  logic reset,
  input  logic load,
  input  logic step,
  output logic p_bit
);

  logic [7:1] lfsr;

  assign p_bit = lfsr[7] ^ lfsr[4];

  // Reseed on reset/load, otherwise shift the feedback bit in once per step
  always_ff @(posedge Clk) begin
    if (reset || load) begin
      lfsr <= PRBS_SEED;
    end else if (step) begin
      lfsr <= {lfsr[6:1], p_bit};
    end
  end

endmodule
`default_nettype wire

// File: rtl/ofdm_subcarrier_mapper.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_subcarrier_mapper
// Brief    : Maps a captured coded frame onto 64-bin 802.11a OFDM symbols
//            (BPSK/QPSK data, PRBS-polarised pilots, nulls) and streams one
//            bin per accepted valid/ready beat.
// Revision : 1.0 - initial release
// ============================================================================
module ofdm_subcarrier_mapper
  import ofdm_subcarrier_mapper_pkg::*;
#(
  parameter int FRAME_BITS = 180,
  parameter int IQ_W       = 8,
  parameter int AMP_BPSK   = 64,
  parameter int AMP_QPSK   = 45
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic [FRAME_BITS-1:0]  frame_in,
  input  logic                   frame_valid,
  input  logic                   qpsk,
  output logic                   in_ready,
  output logic signed [IQ_W-1:0] out_i,
  output logic signed [IQ_W-1:0] out_q,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sym_start,
  output logic                   sym_last,
  output logic                   frame_done
);

  localparam int NSYM_BPSK = (FRAME_BITS + 47) / 48;
  localparam int NSYM_QPSK = (FRAME_BITS + 95) / 96;
  localparam int PAD_W     = 256;
  localparam logic [5:0] LAST_BIN = 6'(NUM_BINS - 1);

  localparam logic signed [IQ_W-1:0] BPSK_P = IQ_W'(AMP_BPSK);
  localparam logic signed [IQ_W-1:0] BPSK_N = IQ_W'(-AMP_BPSK);
  localparam logic signed [IQ_W-1:0] QPSK_P = IQ_W'(AMP_QPSK);
  localparam logic signed [IQ_W-1:0] QPSK_N = IQ_W'(-AMP_QPSK);

  state_t                  state;
  logic                    armed;
  logic [FRAME_BITS-1:0]   frame_r;
  logic                    qpsk_r;
  logic [5:0]              bin;
  logic [2:0]              sym;

  logic                    capture;
  logic                    end_of_frame;
  logic                    prbs_step;
  logic                    p_bit;
  logic [2:0]              last_sym;
  logic [5:0]              nxt_bin;
  logic [2:0]              nxt_sym;
  logic [PAD_W-1:0]        frame_pad;
  bin_info_t               info;
  logic [7:0]              g_i;
  logic [7:0]              g_q;
  logic signed [IQ_W-1:0]  nxt_i;
  logic signed [IQ_W-1:0]  nxt_q;

  // Bits beyond the frame read as 0, so zero-extend to the full 8-bit index range
  assign frame_pad    = PAD_W'(frame_r);
  assign in_ready     = (state == IDLE) && armed;
  assign capture      = (state == IDLE) && frame_valid && armed;
  assign last_sym     = qpsk_r ? 3'(NSYM_QPSK - 1) : 3'(NSYM_BPSK - 1);
  assign end_of_frame = (bin == LAST_BIN) && (sym == last_sym);
  assign prbs_step    = (state == EMIT) && out_ready && (bin == LAST_BIN) && !end_of_frame;
  assign nxt_bin      = capture ? 6'd0 : bin + 6'd1;
  assign nxt_sym      = capture ? 3'd0 : ((bin == LAST_BIN) ? sym + 3'd1 : sym);

  pilot_prbs u_pilot_prbs (
    .Clk   (Clk),
    .reset (reset),
    .load  (capture),
    .step  (prbs_step),
    .p_bit (p_bit)
  );

  // I/Q value of the bin that will be presented after the next transfer;
  // pilots never follow a symbol wrap directly, so p_bit is already current
  always_comb begin
    info  = bin_to_data_idx(nxt_bin);
    g_i   = qpsk_r ? (8'(nxt_sym) * 8'd96 + {1'b0, info.d, 1'b0})
                   : (8'(nxt_sym) * 8'd48 + {2'b00, info.d});
    g_q   = g_i + 8'd1;
    nxt_i = '0;
    nxt_q = '0;
    if (info.is_pilot) begin
      nxt_i = (pilot_base_neg(nxt_bin) ^ p_bit) ? BPSK_N : BPSK_P;
    end else if (info.is_data) begin
      if (qpsk_r) begin
        nxt_i = frame_pad[g_i] ? QPSK_P : QPSK_N;
        nxt_q = frame_pad[g_q] ? QPSK_P : QPSK_N;
      end else begin
        nxt_i = frame_pad[g_i] ? BPSK_P : BPSK_N;
      end
    end
  end

  // Frame capture / bin sequencing FSM with registered stream outputs
  always_ff @(posedge Clk) begin
    if (reset) begin
      state      <= IDLE;
      armed      <= 1'b1;
      frame_r    <= '0;
      qpsk_r     <= 1'b0;
      bin        <= '0;
      sym        <= '0;
      out_valid  <= 1'b0;
      out_i      <= '0;
      out_q      <= '0;
      sym_start  <= 1'b0;
      sym_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!frame_valid) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (capture) begin
            frame_r   <= frame_in;
            qpsk_r    <= qpsk;
            armed     <= 1'b0;
            bin       <= '0;
            sym       <= '0;
            out_valid <= 1'b1;
            out_i     <= '0;
            out_q     <= '0;
            sym_start <= 1'b1;
            sym_last  <= 1'b0;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (end_of_frame) begin
              out_valid  <= 1'b0;
              out_i      <= '0;
              out_q      <= '0;
              sym_start  <= 1'b0;
              sym_last   <= 1'b0;
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              bin       <= nxt_bin;
              sym       <= nxt_sym;
              out_i     <= nxt_i;
              out_q     <= nxt_q;
              sym_start <= (nxt_bin == 6'd0);
              sym_last  <= (nxt_bin == LAST_BIN) && (nxt_sym == last_sym);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ofdm_subcarrier_mapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofdm_subcarrier_mapper
// Brief    : Scoreboard bench for ofdm_subcarrier_mapper with a subcarrier-
//            level reference model and randomized frames/backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofdm_subcarrier_mapper;

  localparam int FB  = 180;
  localparam int IQW = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [FB-1:0]         frame_in = '0;
  logic                  frame_valid = 1'b0;
  logic                  qpsk = 1'b0;
  logic                  out_ready = 1'b0;
  logic                  in_ready;
  logic signed [IQW-1:0] out_i;
  logic signed [IQW-1:0] out_q;
  logic                  out_valid;
  logic                  sym_start;
  logic                  sym_last;
  logic                  frame_done;

  typedef struct {
    int i;
    int q;
    bit ss;
    bit sl;
  } beat_t;

  beat_t exp_q[$];
  int    passed = 0;
  int    total = 0;
  int    beats_seen = 0;
  int    done_seen = 0;
  int    ready_mode = 0;
  bit    done_due = 1'b0;

  ofdm_subcarrier_mapper dut (
    .Clk         (clk),
    .reset       (reset),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .qpsk        (qpsk),
    .in_ready    (in_ready),
    .out_i       (out_i),
    .out_q       (out_q),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sym_start   (sym_start),
    .sym_last    (sym_last),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (beat %0d)", name, act, exp, beats_seen);
  endtask

  function automatic bit bitval(input logic [FB-1:0] bits, input int g);
    return (g < FB) ? bits[g] : 1'b0;
  endfunction

  // Reference model: walk subcarriers s = -32..31 in IFFT order per symbol
  task automatic push_frame(input logic [FB-1:0] bits, input bit q);
    bit x[1:7];
    int nsym, s, a, d, g, base;
    bit p, fb;
    for (int k = 1; k <= 7; k++) x[k] = 1'b1;
    nsym = q ? (FB + 95) / 96 : (FB + 47) / 48;
    for (int sy = 0; sy < nsym; sy++) begin
      p = x[7] ^ x[4];
      for (int b = 0; b < 64; b++) begin
        beat_t e;
        e.i = 0; e.q = 0;
        e.ss = (b == 0);
        e.sl = (b == 63) && (sy == nsym - 1);
        s = (b < 32) ? b : b - 64;
        a = (s < 0) ? -s : s;
        if (s == 0 || a > 26) begin
          e.i = 0;
        end else if (a == 7 || a == 21) begin
          base = (s == 21) ? -1 : 1;
          e.i = base * (p ? -1 : 1) * 64;
        end else begin
          if (s < -21)     d = s + 26;
          else if (s < -7) d = s + 25;
          else if (s < 0)  d = s + 24;
          else if (s < 7)  d = s + 23;
          else if (s < 21) d = s + 22;
          else             d = s + 21;
          if (q) begin
            g = sy * 96 + 2 * d;
            e.i = bitval(bits, g) ? 45 : -45;
            e.q = bitval(bits, g + 1) ? 45 : -45;
          end else begin
            g = sy * 48 + d;
            e.i = bitval(bits, g) ? 64 : -64;
          end
        end
        exp_q.push_back(e);
      end
      fb = x[7] ^ x[4];
      for (int k = 7; k >= 2; k--) x[k] = x[k-1];
      x[1] = fb;
    end
  endtask

  // Downstream ready pattern: always, 2-of-3 (one stall in three), random
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cnt % 3) != 0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      cnt++;
    end
  end

  // Monitor: pop/compare on each transferring beat, check stall stability
  initial begin
    beat_t e;
    int    ai, aq, held, cur;
    bit    hold_pending;
    hold_pending = 1'b0;
    held = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        done_due = 1'b0;
        hold_pending = 1'b0;
        continue;
      end
      if (frame_done || done_due) check("frame_done", int'(frame_done), int'(done_due));
      if (frame_done) done_seen++;
      done_due = 1'b0;
      ai = out_i;
      aq = out_q;
      cur = {out_valid, sym_start, sym_last, out_i, out_q};
      if (hold_pending) begin
        check("stall_hold", cur, held);
        hold_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", int'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_i", ai, e.i);
          check("beat_q", aq, e.q);
          check("sym_start", int'(sym_start), int'(e.ss));
          check("sym_last", int'(sym_last), int'(e.sl));
          beats_seen++;
          if (e.sl) done_due = 1'b1;
        end
      end else if (out_valid) begin
        held = cur;
        hold_pending = 1'b1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < budget) begin
      tick();
      c++;
    end
    if (c >= budget) begin
      total++;
      $display("FAIL drain_timeout: %0d beats still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
    tick(2);
  endtask

  task automatic send_frame(input logic [FB-1:0] bits, input bit q);
    int b0, d0;
    b0 = beats_seen;
    d0 = done_seen;
    check("in_ready_idle", int'(in_ready), 1);
    frame_in = bits;
    qpsk = q;
    frame_valid = 1'b1;
    push_frame(bits, q);
    tick(1);
    frame_valid = 1'b0;
    wait_drain(4000);
    check("beat_count", beats_seen - b0, q ? 128 : 256);
    check("done_count", done_seen - d0, 1);
  endtask

  initial begin
    logic [FB-1:0] bits;
    int b0, d0, c;

    // Reset state
    reset = 1'b1;
    tick(3);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_out_i", int'(out_i), 0);
    check("rst_sym_start", int'(sym_start), 0);
    reset = 1'b0;
    tick(2);

    // BPSK all ones, no stalls
    ready_mode = 0;
    send_frame('1, 1'b0);

    // QPSK with only bit 0 set
    bits = '0;
    bits[0] = 1'b1;
    send_frame(bits, 1'b1);

    // Backpressure on the all-ones BPSK frame
    ready_mode = 1;
    send_frame('1, 1'b0);

    // Level-held frame_valid is accepted once
    ready_mode = 0;
    b0 = beats_seen;
    d0 = done_seen;
    frame_in = '1;
    qpsk = 1'b0;
    frame_valid = 1'b1;
    push_frame('1, 1'b0);
    tick(1000);
    check("held_beats", beats_seen - b0, 256);
    check("held_done", done_seen - d0, 1);
    check("held_in_ready", int'(in_ready), 0);
    frame_valid = 1'b0;
    tick(1);
    check("rearm_in_ready", int'(in_ready), 1);
    for (int k = 0; k < FB; k++) bits[k] = 1'($urandom_range(0, 1));
    send_frame(bits, 1'b1);

    // Reset in the middle of symbol 1
    b0 = beats_seen;
    d0 = done_seen;
    frame_in = '1;
    qpsk = 1'b0;
    frame_valid = 1'b1;
    push_frame('1, 1'b0);
    tick(1);
    frame_valid = 1'b0;
    c = 0;
    while ((beats_seen - b0) < 94 && c < 500) begin
      tick();
      c++;
    end
    check("pre_reset_beats", beats_seen - b0, 94);
    reset = 1'b1;
    exp_q.delete();
    tick(1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_frame_done", int'(frame_done), 0);
    reset = 1'b0;
    tick(3);
    check("midrst_no_done", done_seen - d0, 0);
    send_frame('1, 1'b0);

    // Randomized frames, modulation and backpressure
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < FB; k++) bits[k] = 1'($urandom_range(0, 1));
      ready_mode = $urandom_range(0, 2);
      send_frame(bits, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
